// File: rtl/pix_pkg.sv
// Shared pixel/window constants, FSM state encoding and window byte indexing.
package pix_pkg;

    localparam int PIX_W = 8;
    localparam int K     = 5;
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Bit offset of window byte (row r, column c); row 0 is the oldest row, column 0 the oldest column.
    function automatic int idx(input int r, input int c);
        return (r * K + c) * PIX_W;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// K x K pixel register window; each enabled cycle the columns move one place toward column 0
// and the new K-pixel column enters at column K-1.
module window_shift_reg
    import pix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_en,
    input  logic [K*PIX_W-1:0]     col_i,
    output logic [K*K*PIX_W-1:0]   win_o
);

    logic [K*K*PIX_W-1:0] win_d;
    logic [K*K*PIX_W-1:0] win_q;

    // Next window: hold, or shift columns left and append the incoming column.
    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[idx(r, c) +: PIX_W] = win_q[idx(r, c + 1) +: PIX_W];
                end
                win_d[idx(r, K - 1) +: PIX_W] = col_i[r*PIX_W +: PIX_W];
            end
        end
    end

    // Window register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) win_q <= '0;
        else      win_q <= win_d;
    end

    assign win_o = win_q;

endmodule

// File: rtl/window_5x5_builder.sv
// Builds 5x5 pixel windows from five aligned line-buffer taps. Tracks the accepted pixel
// position, flags windows that lie fully inside the frame, and pulses done_o after a full frame.
// Handshake: valid_i=1 means one pixel column is accepted this cycle (there is no back-pressure);
// valid_o=1 means window_o holds a complete in-frame window for exactly that cycle.
module window_5x5_builder
    import pix_pkg::*;
#(
    parameter int WIDTH  = 17,
    parameter int HEIGHT = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [PIX_W-1:0]     data0_i,
    input  logic [PIX_W-1:0]     data1_i,
    input  logic [PIX_W-1:0]     data2_i,
    input  logic [PIX_W-1:0]     data3_i,
    input  logic [PIX_W-1:0]     data4_i,
    input  logic                 done_i,
    output logic [K*K*PIX_W-1:0] window_o,
    output logic                 valid_o,
    output logic                 done_o
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] EDGE     = CNT_W'(K - 1);

    logic [CNT_W-1:0] col_d, col_q;
    logic [CNT_W-1:0] row_d, row_q;
    state_e           state_d, state_q;
    logic             valid_d, valid_q;
    logic             done_d, done_q;
    logic             last_px;

    // Row 0 of the window is the oldest tap, so data4 sits in the low byte of the column.
    window_shift_reg u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (valid_i),
        .col_i    ({data0_i, data1_i, data2_i, data3_i, data4_i}),
        .win_o    (window_o)
    );

    // Position counters, frame FSM next state, and window-valid / done generation.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        valid_d = 1'b0;
        done_d  = (state_q == ST_DONE);
        last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);

        if (valid_i) begin
            // The first four columns of each row still hold stale columns of the previous row.
            valid_d = (row_q >= EDGE) && (col_q >= EDGE);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            state_d = last_px ? ST_DONE : ST_ACTIVE;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end

        // Upstream abort resynchronises the position; the pulse of a finished frame is not cut short.
        if (done_i && (state_q != ST_DONE)) begin
            col_d   = '0;
            row_d   = '0;
            state_d = ST_IDLE;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;

endmodule
